// File: rtl/joy_db15_pkg.sv
// joy_db15_pkg
//   Shared constants, state encoding and frame-building helper for the DB15
//   joystick serial responder.
//   - FRAME_BITS  : bits per host frame (two players)
//   - PLAYER_BITS : button/direction bits per player
//   - CNT_W       : width of the frame bit counter
//   - db15_tx_state_t : responder state encoding
//   - build_frame() : packs both players into the active-low shift image
package joy_db15_pkg;

    localparam int FRAME_BITS  = 24;
    localparam int PLAYER_BITS = 12;
    localparam int CNT_W       = 5;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } db15_tx_state_t;

    // Bit 0 of the result leaves first: player 1 bit 0 up to player 2 bit 11.
    // Inputs are active-high, the wire is active-low, hence the inversion.
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic [PLAYER_BITS-1:0] j1,
        input logic [PLAYER_BITS-1:0] j2
    );
        return {~j2, ~j1};
    endfunction

endpackage

// File: rtl/joy_db15_tx_sync_filter_edge.sv
// sync_filter_edge
//   Brings an asynchronous strobe into the clk domain, rejects pulses that
//   do not hold for FILTER consecutive samples, and flags accepted edges.
//   Ports:
//     clk      in   system clock
//     reset    in   asynchronous active-high reset (level resets to 1)
//     async_in in   raw asynchronous strobe
//     level    out  filtered, accepted level (registered)
//     rise     out  accepted 0->1 change this cycle (combinational)
//     fall     out  accepted 1->0 change this cycle (combinational)
//   rise/fall are asserted in the same cycle that level is about to update,
//   so a consumer registering on them adds no extra cycle: total latency from
//   the pin to the consumer's register is SYNC_STAGES + FILTER.
module sync_filter_edge #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER      = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CW = (FILTER > 1) ? $clog2(FILTER + 1) : 1;

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   level_reg;
    logic [CW-1:0]          cnt_reg;
    logic                   synced;
    logic                   accept;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_reg <= '1;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], async_in};
        end
    end

    assign synced = sync_reg[SYNC_STAGES-1];

    // cnt_reg counts how many previous samples already disagreed with the
    // accepted level; the FILTER-th disagreeing sample is accepted.
    assign accept = (synced != level_reg) && (cnt_reg == CW'(FILTER - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_reg <= 1'b1;
            cnt_reg   <= '0;
        end else if (synced == level_reg) begin
            cnt_reg <= '0;
        end else if (accept) begin
            level_reg <= synced;
            cnt_reg   <= '0;
        end else begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

    assign level = level_reg;
    assign rise  = accept & synced;
    assign fall  = accept & ~synced;

endmodule

// File: rtl/joy_db15_tx.sv
// joy_db15_tx
//   Emulates the parallel-in/serial-out shift chain of a two-player DB15
//   adapter, answering host JOY_LOAD/JOY_CLK strobes on JOY_DATA.
//   Ports:
//     clk        in   system clock
//     reset      in   asynchronous active-high reset
//     joystick1  in   player-1 states, 1 = pressed
//     joystick2  in   player-2 states, 1 = pressed
//     JOY_LOAD   in   host load strobe, active low, asynchronous
//     JOY_CLK    in   host shift clock, rising edge, asynchronous
//     JOY_DATA   out  serial data, active low, registered
//     frame_done out  one-cycle pulse after the 24th bit is shifted out
//     overrun    out  sticky: host clocked past the end of the frame
module joy_db15_tx
    import joy_db15_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER      = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [PLAYER_BITS-1:0] joystick1,
    input  logic [PLAYER_BITS-1:0] joystick2,
    input  logic                   JOY_LOAD,
    input  logic                   JOY_CLK,
    output logic                   JOY_DATA,
    output logic                   frame_done,
    output logic                   overrun
);

    logic load_level;
    logic load_rise;
    logic load_fall;
    logic clk_level;
    logic clk_rise;
    logic clk_fall;

    sync_filter_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER      (FILTER)
    ) u_load_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (JOY_LOAD),
        .level    (load_level),
        .rise     (load_rise),
        .fall     (load_fall)
    );

    sync_filter_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER      (FILTER)
    ) u_clk_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (JOY_CLK),
        .level    (clk_level),
        .rise     (clk_rise),
        .fall     (clk_fall)
    );

    db15_tx_state_t         state_reg,      state_next;
    logic [FRAME_BITS-1:0]  shift_reg,      shift_next;
    logic [CNT_W-1:0]       bit_cnt_reg,    bit_cnt_next;
    logic                   data_reg,       data_next;
    logic                   frame_done_reg, frame_done_next;
    logic                   overrun_reg,    overrun_next;

    logic [FRAME_BITS-1:0]  shifted;
    logic                   load_active;

    // Load is held (filtered level low) unless its release is being accepted
    // this very cycle; a newly accepted fall also counts. Load takes priority
    // over any JOY_CLK edge accepted in the same cycle.
    assign load_active = load_fall | (~load_level & ~load_rise);

    // Shift towards bit 0; vacated bits read as "not pressed".
    assign shifted = {1'b1, shift_reg[FRAME_BITS-1:1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            shift_reg      <= '1;
            bit_cnt_reg    <= '0;
            data_reg       <= 1'b1;
            frame_done_reg <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            shift_reg      <= shift_next;
            bit_cnt_reg    <= bit_cnt_next;
            data_reg       <= data_next;
            frame_done_reg <= frame_done_next;
            overrun_reg    <= overrun_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        shift_next      = shift_reg;
        bit_cnt_next    = bit_cnt_reg;
        data_next       = data_reg;
        frame_done_next = 1'b0;
        overrun_next    = overrun_reg;

        if (load_active) begin
            // Continuous parallel load: the frame is whatever the inputs
            // hold on the last cycle before the load is released.
            state_next   = LOAD;
            shift_next   = build_frame(joystick1, joystick2);
            data_next    = ~joystick1[0];
            bit_cnt_next = '0;
            overrun_next = 1'b0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    data_next = 1'b1;
                end
                LOAD: begin
                    if (load_rise) begin
                        state_next = SHIFT;
                    end
                end
                SHIFT: begin
                    if (clk_rise) begin
                        shift_next   = shifted;
                        bit_cnt_next = bit_cnt_reg + CNT_W'(1);
                        if (bit_cnt_reg == CNT_W'(FRAME_BITS - 1)) begin
                            state_next      = DONE;
                            frame_done_next = 1'b1;
                            data_next       = 1'b1;
                        end else begin
                            data_next = shifted[0];
                        end
                    end
                end
                DONE: begin
                    // bit_cnt stays saturated at FRAME_BITS here.
                    data_next = 1'b1;
                    if (clk_rise) begin
                        overrun_next = 1'b1;
                    end
                end
                default: begin
                    state_next = IDLE;
                    data_next  = 1'b1;
                end
            endcase
        end
    end

    assign JOY_DATA   = data_reg;
    assign frame_done = frame_done_reg;
    assign overrun    = overrun_reg;

endmodule

// File: tb/tb_joy_db15_tx.sv
// tb_joy_db15_tx
//   Directed bench for joy_db15_tx. Expected serial bits are pushed to a
//   scoreboard queue when a frame is loaded and popped as the host samples.
module tb_joy_db15_tx;

    localparam int HALF = 8;   // host strobe phase length in clk cycles

    logic        clk;
    logic        reset;
    logic [11:0] joystick1;
    logic [11:0] joystick2;
    logic        JOY_LOAD;
    logic        JOY_CLK;
    logic        JOY_DATA;
    logic        frame_done;
    logic        overrun;

    int   checks   = 0;
    int   errors   = 0;
    int   fd_count = 0;
    int   fd_exp   = 0;
    bit   toggle_inputs = 0;
    logic exp_q[$];

    joy_db15_tx #(
        .SYNC_STAGES (2),
        .FILTER      (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .joystick1  (joystick1),
        .joystick2  (joystick2),
        .JOY_LOAD   (JOY_LOAD),
        .JOY_CLK    (JOY_CLK),
        .JOY_DATA   (JOY_DATA),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_count++;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
        $display("check %-10s observed=%b expected=%b", tag, obs, expv);
    endtask

    task automatic check_int(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
        $display("check %-10s observed=%0d expected=%0d", tag, obs, expv);
    endtask

    task automatic push_frame(input logic [11:0] j1, input logic [11:0] j2);
        for (int i = 0; i < 12; i++) exp_q.push_back(~j1[i]);
        for (int i = 0; i < 12; i++) exp_q.push_back(~j2[i]);
    endtask

    task automatic load_low();
        JOY_LOAD = 1'b0;
        wait_cyc(HALF);
    endtask

    task automatic load_high();
        JOY_LOAD = 1'b1;
        wait_cyc(HALF);
    endtask

    // Sample just before the rising edge, then clock one bit.
    task automatic host_bit();
        logic e;
        if (exp_q.size() == 0) begin
            e = 1'b1;
            check_int("sb_empty", 0, 1);
        end else begin
            e = exp_q.pop_front();
        end
        check_bit("bit", JOY_DATA, e);
        JOY_CLK = 1'b1;
        wait_cyc(HALF);
        if (toggle_inputs) begin
            joystick1 = 12'($urandom);
            joystick2 = 12'($urandom);
        end
        JOY_CLK = 1'b0;
        wait_cyc(HALF);
    endtask

    task automatic load_frame(input logic [11:0] j1, input logic [11:0] j2);
        joystick1 = j1;
        joystick2 = j2;
        load_low();
        exp_q.delete();
        push_frame(j1, j2);
        load_high();
    endtask

    initial begin
        reset     = 1'b1;
        JOY_LOAD  = 1'b1;
        JOY_CLK   = 1'b0;
        joystick1 = '0;
        joystick2 = '0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        wait_cyc(HALF);

        // Reset state and IDLE ignoring clock edges
        check_bit("rst_data", JOY_DATA, 1'b1);
        check_bit("rst_fd", frame_done, 1'b0);
        check_bit("rst_ovr", overrun, 1'b0);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(1'b1);
            host_bit();
        end
        check_bit("idle_ovr", overrun, 1'b0);
        check_int("idle_fd", fd_count, fd_exp);

        // Basic frame
        load_frame(12'h005, 12'h800);
        for (int i = 0; i < 24; i++) host_bit();
        fd_exp++;
        check_int("fd_basic", fd_count, fd_exp);
        check_bit("end_data", JOY_DATA, 1'b1);

        // Back-to-back frames with inputs changing during shift
        toggle_inputs = 1;
        load_frame(12'hA5C, 12'h3F1);
        for (int i = 0; i < 24; i++) host_bit();
        load_frame(12'h1E7, 12'hC42);
        for (int i = 0; i < 24; i++) host_bit();
        toggle_inputs = 0;
        fd_exp += 2;
        check_int("fd_b2b", fd_count, fd_exp);

        // Aborted frame after 10 bits, then a full frame
        load_frame(12'h0F0, 12'h00F);
        for (int i = 0; i < 10; i++) host_bit();
        load_frame(12'h9A6, 12'h5B3);
        check_int("fd_abort", fd_count, fd_exp);
        for (int i = 0; i < 24; i++) host_bit();
        fd_exp++;
        check_int("fd_reload", fd_count, fd_exp);

        // Overrun after clocking past the frame
        load_frame(12'h123, 12'h456);
        for (int i = 0; i < 24; i++) host_bit();
        fd_exp++;
        check_bit("ovr_24", overrun, 1'b0);
        exp_q.push_back(1'b1);
        host_bit();
        check_bit("ovr_25", overrun, 1'b1);
        check_bit("ovr_data", JOY_DATA, 1'b1);
        exp_q.push_back(1'b1);
        host_bit();
        check_bit("ovr_26", overrun, 1'b1);
        check_int("fd_ovr", fd_count, fd_exp);
        joystick1 = 12'h7FE;
        load_low();
        check_bit("ovr_clr", overrun, 1'b0);
        check_bit("load_data", JOY_DATA, 1'b1);
        load_high();

        // One-cycle JOY_CLK glitch must not shift
        load_frame(12'h2D9, 12'hB16);
        for (int i = 0; i < 5; i++) host_bit();
        JOY_CLK = 1'b1;
        @(negedge clk);
        JOY_CLK = 1'b0;
        wait_cyc(HALF);
        check_bit("glitch", JOY_DATA, exp_q[0]);
        for (int i = 0; i < 19; i++) host_bit();
        fd_exp++;
        check_int("fd_glitch", fd_count, fd_exp);

        // Load coincident with the 24th clock edge: load wins, no frame_done
        load_frame(12'h6C3, 12'h93C);
        for (int i = 0; i < 23; i++) host_bit();
        joystick1 = 12'h001;
        joystick2 = 12'hFFE;
        JOY_LOAD  = 1'b0;
        JOY_CLK   = 1'b1;
        wait_cyc(HALF);
        check_bit("coinc_data", JOY_DATA, 1'b0);
        JOY_CLK = 1'b0;
        wait_cyc(HALF);
        check_int("fd_coinc", fd_count, fd_exp);
        exp_q.delete();
        push_frame(12'h001, 12'hFFE);
        load_high();
        for (int i = 0; i < 24; i++) host_bit();
        fd_exp++;
        check_int("fd_after", fd_count, fd_exp);

        // Reset mid-frame at bit 12
        load_frame(12'h000, 12'h000);
        for (int i = 0; i < 12; i++) host_bit();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_bit("mrst_data", JOY_DATA, 1'b1);
        check_bit("mrst_fd", frame_done, 1'b0);
        check_bit("mrst_ovr", overrun, 1'b0);
        wait_cyc(3);
        reset = 1'b0;
        wait_cyc(HALF);
        exp_q.delete();
        for (int i = 0; i < 14; i++) begin
            exp_q.push_back(1'b1);
            host_bit();
        end
        check_int("fd_mrst", fd_count, fd_exp);
        check_bit("mrst_ovr2", overrun, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
